// File: rtl/jpeg_pkg.sv
// Shared types and helpers for the JPEG dequantise / de-zigzag stage.
package jpeg_pkg;

    // Life cycle of one coefficient block bank.
    typedef enum logic [1:0] {
        FREE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2,
        READ = 2'd3
    } bank_state_t;

    // Zigzag scan index -> natural (row-major) index inside the 8x8 block.
    localparam logic [5:0] ZZ2NAT [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Clamp a signed value to the range of a signed w-bit number (w <= 31).
    function automatic logic signed [31:0] saturate(input logic signed [31:0] x, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/jpeg_coef_bank.sv
// One 8x8 coefficient bank: 64-entry storage, written-bitmap, one write
// port and an 8-wide row read. Entries never written since the last clear
// read back as zero, so a block needs no explicit zero-fill pass.
module jpeg_coef_bank #(
    parameter int COEF_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                wr_en_i,
    input  logic [5:0]          wr_addr_i,
    input  logic [COEF_W-1:0]   wr_data_i,
    input  logic [2:0]          rd_row_i,
    output logic [8*COEF_W-1:0] rd_data_o
);
    logic [COEF_W-1:0] mem_q [64];
    logic [63:0]       written_q;

    // Coefficient storage write port.
    // NOTE: storage has no reset; the bitmap alone decides whether an entry is valid.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    // Written-bitmap: cleared when the bank is allocated, one bit set per write.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            written_q <= '0;
        end else begin
            if (clr_i)   written_q <= '0;
            if (wr_en_i) written_q[wr_addr_i] <= 1'b1;
        end
    end

    // Row read, masking entries not written in the current block.
    // NOTE: the output gets a default before the loop so no latch is inferred.
    always_comb begin
        rd_data_o = '0;
        for (int c = 0; c < 8; c++) begin
            if (written_q[{rd_row_i, 3'(c)}])
                rd_data_o[c*COEF_W +: COEF_W] = mem_q[{rd_row_i, 3'(c)}];
        end
    end

endmodule

// File: rtl/jpeg_dequant_shuffle.sv
// De-zigzag and dequantisation stage between the run-length decoder and the
// IDCT. Tokens are sign-extended, scaled by the block's quant table and
// written at their natural position into a rotating set of block banks.
module jpeg_dequant_shuffle
    import jpeg_pkg::*;
#(
    parameter int COEF_W = 16,
    parameter int AMP_W  = 11,
    parameter int QT_W   = 8,
    parameter int NUM_QT = 4,
    parameter int NBANK  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      qt_wr,
    input  logic [$clog2(NUM_QT)-1:0] qt_sel,
    input  logic [5:0]                qt_addr,
    input  logic [QT_W-1:0]           qt_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                in_run,
    input  logic [3:0]                in_size,
    input  logic [AMP_W-1:0]          in_amp,
    input  logic                      in_eob,
    input  logic [$clog2(NUM_QT)-1:0] in_tbl,
    output logic                      rd_avail,
    input  logic [2:0]                rd_row,
    output logic [8*COEF_W-1:0]       rd_data,
    input  logic                      rd_done,
    output logic                      err
);
    localparam int TBL_W  = $clog2(NUM_QT);
    localparam int BANK_W = $clog2(NBANK);
    localparam int VAL_W  = AMP_W + 1;
    localparam int PROD_W = VAL_W + QT_W + 1;

    function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
        return (b == BANK_W'(NBANK - 1)) ? '0 : b + 1'b1;
    endfunction

    // Block bookkeeping state
    bank_state_t        bank_state_q [NBANK];
    bank_state_t        bank_state_d [NBANK];
    logic [BANK_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [BANK_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic               filling_q, filling_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [TBL_W-1:0]   tbl_q, tbl_d;
    logic               err_q, err_d;

    // Pipeline registers
    logic               s1_wr_q, s1_end_q;
    logic [BANK_W-1:0]  s1_bank_q;
    logic [TBL_W-1:0]   s1_tbl_q;
    logic [5:0]         s1_zz_q;
    logic signed [VAL_W-1:0] s1_val_q;
    logic               s2_wr_q, s2_end_q;
    logic [BANK_W-1:0]  s2_bank_q;
    logic [5:0]         s2_nat_q;
    logic [QT_W-1:0]    s2_qt_q;
    logic signed [VAL_W-1:0] s2_val_q;

    logic [QT_W-1:0]    qt_mem [NUM_QT*64];
    logic [8*COEF_W-1:0] rd_data_q;
    logic [8*COEF_W-1:0] bank_rows [NBANK];

    // Token decode
    logic               accept, alloc, rd_release;
    logic [6:0]         pos;
    logic               tok_coef, tok_zrl, tok_eob, overflow, tok_end, tok_wr;
    logic [TBL_W-1:0]   tok_tbl;
    logic [VAL_W-1:0]   amp_x, size_mask, size_msb;
    logic signed [VAL_W-1:0] ext_val;
    logic signed [PROD_W-1:0] prod;
    logic [COEF_W-1:0]  coef;

    assign in_ready   = !rst && (filling_q || bank_state_q[wr_ptr_q] == FREE);
    assign accept     = in_valid && in_ready;
    assign alloc      = accept && !filling_q;
    assign rd_avail   = (bank_state_q[rd_ptr_q] == READ);
    assign rd_release = rd_done && rd_avail;
    assign rd_data    = rd_data_q;
    assign err        = err_q;

    // Classify the incoming token and work out its zigzag position.
    always_comb begin
        pos      = 7'(cnt_q) + 7'(in_run);
        tok_coef = !in_eob && (in_size != 4'd0);
        tok_zrl  = !in_eob && (in_size == 4'd0) && (in_run == 4'd15);
        tok_eob  = in_eob || ((in_size == 4'd0) && (in_run != 4'd15));
        overflow = (tok_coef || tok_zrl) && pos[6];
        tok_end  = tok_eob || overflow || (pos == 7'd63);
        tok_wr   = accept && tok_coef && !overflow;
        tok_tbl  = filling_q ? tbl_q : in_tbl;
    end

    // JPEG EXTEND: a clear top amplitude bit marks a negative value.
    always_comb begin
        size_mask = (VAL_W'(1) << in_size) - VAL_W'(1);
        size_msb  = (VAL_W'(1) << in_size) >> 1;
        amp_x     = {1'b0, in_amp} & size_mask;
        if ((amp_x & size_msb) != '0) ext_val = $signed(amp_x);
        else                          ext_val = $signed(amp_x - size_mask);
    end

    // Bank rotation, position counter and error flag: next state.
    always_comb begin
        bank_state_d = bank_state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        filling_d    = filling_q;
        cnt_d        = cnt_q;
        tbl_d        = tbl_q;
        err_d        = err_q;
        // Release is applied before allocation so a freed bank is seen as FREE.
        if (rd_release) begin
            bank_state_d[rd_ptr_q] = FREE;
            rd_ptr_d               = next_bank(rd_ptr_q);
        end else if (bank_state_q[rd_ptr_q] == FULL) begin
            bank_state_d[rd_ptr_q] = READ;
        end
        if (alloc) begin
            bank_state_d[wr_ptr_q] = FILL;
            tbl_d                  = in_tbl;
        end
        if (accept) begin
            cnt_d     = tok_end ? 6'd0 : pos[5:0] + 6'd1;
            filling_d = !tok_end;
            if (tok_end)  wr_ptr_d = next_bank(wr_ptr_q);
            if (overflow) err_d    = 1'b1;
        end
        // The block's end marker leaves the pipeline after its last write.
        if (s2_end_q) bank_state_d[s2_bank_q] = FULL;
    end

    // Bank rotation, position counter and error flag: registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NBANK; b++) bank_state_q[b] <= FREE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            filling_q <= 1'b0;
            cnt_q     <= '0;
            tbl_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            bank_state_q <= bank_state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            filling_q    <= filling_d;
            cnt_q        <= cnt_d;
            tbl_q        <= tbl_d;
            err_q        <= err_d;
        end
    end

    // Pipeline control bits: reset so a block cut by reset never lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_wr_q  <= 1'b0;
            s1_end_q <= 1'b0;
            s2_wr_q  <= 1'b0;
            s2_end_q <= 1'b0;
        end else begin
            s1_wr_q  <= tok_wr;
            s1_end_q <= accept && tok_end;
            s2_wr_q  <= s1_wr_q;
            s2_end_q <= s1_end_q;
        end
    end

    // Pipeline data: S1 captures the token, S2 the zigzag and quant lookups.
    always_ff @(posedge clk) begin
        s1_bank_q <= wr_ptr_q;
        s1_tbl_q  <= tok_tbl;
        s1_zz_q   <= pos[5:0];
        s1_val_q  <= ext_val;
        s2_bank_q <= s1_bank_q;
        s2_nat_q  <= ZZ2NAT[s1_zz_q];
        s2_val_q  <= s1_val_q;
    end

    // Quant tables: host write port, S2 read returns the pre-write value.
    always_ff @(posedge clk) begin
        if (qt_wr) qt_mem[{qt_sel, qt_addr}] <= qt_data;
        s2_qt_q <= qt_mem[{s1_tbl_q, s1_zz_q}];
    end

    // S3: scale and clamp to the coefficient range.
    always_comb begin
        prod = PROD_W'(s2_val_q) * PROD_W'($signed({1'b0, s2_qt_q}));
        coef = COEF_W'(saturate(32'(prod), COEF_W));
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        jpeg_coef_bank #(.COEF_W(COEF_W)) u_bank (
            .clk       (clk),
            .rst       (rst),
            .clr_i     (alloc && wr_ptr_q == BANK_W'(b)),
            .wr_en_i   (s2_wr_q && s2_bank_q == BANK_W'(b)),
            .wr_addr_i (s2_nat_q),
            .wr_data_i (coef),
            .rd_row_i  (rd_row),
            .rd_data_o (bank_rows[b])
        );
    end

    // Registered row read from the bank being drained; holds while idle.
    always_ff @(posedge clk) begin
        if (rst)           rd_data_q <= '0;
        else if (rd_avail) rd_data_q <= bank_rows[rd_ptr_q];
    end

endmodule

// File: tb/tb_jpeg_dequant_shuffle.sv
// Directed bench for jpeg_dequant_shuffle: hand-computed coefficients,
// bank rotation, back-pressure, saturation and mid-block reset.
module tb_jpeg_dequant_shuffle;
    localparam int COEF_W = 16;
    localparam int AMP_W  = 11;
    localparam int QT_W   = 8;
    localparam int NUM_QT = 4;
    localparam int NBANK  = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                qt_wr = 1'b0;
    logic [1:0]          qt_sel = '0;
    logic [5:0]          qt_addr = '0;
    logic [QT_W-1:0]     qt_data = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [3:0]          in_run = '0;
    logic [3:0]          in_size = '0;
    logic [AMP_W-1:0]    in_amp = '0;
    logic                in_eob = 1'b0;
    logic [1:0]          in_tbl = '0;
    logic                rd_avail;
    logic [2:0]          rd_row = '0;
    logic [8*COEF_W-1:0] rd_data;
    logic                rd_done = 1'b0;
    logic                err;

    int n_cmp = 0;
    int n_err = 0;

    jpeg_dequant_shuffle #(
        .COEF_W(COEF_W), .AMP_W(AMP_W), .QT_W(QT_W), .NUM_QT(NUM_QT), .NBANK(NBANK)
    ) dut (
        .clk(clk), .rst(rst),
        .qt_wr(qt_wr), .qt_sel(qt_sel), .qt_addr(qt_addr), .qt_data(qt_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_run(in_run), .in_size(in_size),
        .in_amp(in_amp), .in_eob(in_eob), .in_tbl(in_tbl),
        .rd_avail(rd_avail), .rd_row(rd_row), .rd_data(rd_data), .rd_done(rd_done),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [COEF_W-1:0] cf(input logic [8*COEF_W-1:0] row, input int c);
        return row[c*COEF_W +: COEF_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic qt_load(input int sel, input int addr, input int val);
        qt_wr   = 1'b1;
        qt_sel  = 2'(sel);
        qt_addr = 6'(addr);
        qt_data = 8'(val);
        tick();
        qt_wr   = 1'b0;
    endtask

    // Offer one token and return just after the edge that accepts it.
    task automatic send_tok(input int run, input int size, input int amp, input bit eob, input int tbl);
        int guard;
        in_valid = 1'b1;
        in_run   = 4'(run);
        in_size  = 4'(size);
        in_amp   = 11'(amp);
        in_eob   = eob;
        in_tbl   = 2'(tbl);
        guard    = 0;
        while (!in_ready && guard < 64) begin
            tick();
            guard++;
        end
        if (!in_ready) check("ready_timeout", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_eob   = 1'b0;
    endtask

    task automatic wait_avail();
        int guard;
        guard = 0;
        while (!rd_avail && guard < 32) begin
            tick();
            guard++;
        end
        if (!rd_avail) check("avail_timeout", rd_avail, 1);
    endtask

    task automatic read_row(input int r, output logic [8*COEF_W-1:0] row);
        rd_row = 3'(r);
        tick();
        row = rd_data;
    endtask

    task automatic release_bank();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
    endtask

    logic [8*COEF_W-1:0] row;
    int nz;
    logic signed [COEF_W-1:0] dc;

    initial begin
        // Reset state
        tick();
        check("rst_ready", in_ready, 0);
        check("rst_avail", rd_avail, 0);
        check("rst_data", rd_data, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", in_ready, 1);

        // Tables: qt0 all 2, qt1 = {3,1,5,1...}, qt2 all 255, qt3 all 1
        for (int i = 0; i < 64; i++) qt_load(0, i, 2);
        for (int i = 0; i < 64; i++) qt_load(1, i, (i == 0) ? 3 : (i == 2) ? 5 : 1);
        for (int i = 0; i < 64; i++) qt_load(2, i, 255);
        for (int i = 0; i < 64; i++) qt_load(3, i, 1);

        // Block 1: DC size 3 amp 010 -> (2-7)*2 = -10, availability latency
        send_tok(0, 3, 3'b010, 0, 0);
        send_tok(0, 0, 0, 1, 0);
        tick();
        tick();
        check("t1_avail_early", rd_avail, 0);
        tick();
        check("t1_avail_latency", rd_avail, 1);
        nz = 0;
        dc = '0;
        for (int r = 0; r < 8; r++) begin
            read_row(r, row);
            for (int c = 0; c < 8; c++) begin
                if (r == 0 && c == 0) dc = cf(row, 0);
                else if (cf(row, c) != 0) nz++;
            end
        end
        check("t1_dc", dc, -10);
        check("t1_zero_fill", nz, 0);
        release_bank();
        check("t1_released", rd_avail, 0);

        // Block 2: table 1 latched on first token; zz2 -> row1 col0
        send_tok(0, 1, 1, 0, 1);
        send_tok(1, 2, 2'b11, 0, 0);
        send_tok(0, 0, 0, 1, 0);
        wait_avail();
        read_row(0, row);
        check("t2_nat0", cf(row, 0), 3);
        check("t2_nat1", cf(row, 1), 0);
        read_row(1, row);
        check("t2_nat8", cf(row, 0), 15);
        release_bank();

        // Block 3: ZRL x3 then run 15 -> zz63, ends without EOB
        for (int i = 0; i < 3; i++) send_tok(15, 0, 0, 0, 0);
        send_tok(15, 1, 1, 0, 0);
        wait_avail();
        check("t3_no_err", err, 0);
        read_row(7, row);
        check("t3_nat63", cf(row, 7), 2);
        release_bank();

        // Block 4: cnt reaches 60, then ZRL overflows
        for (int i = 0; i < 3; i++) send_tok(15, 0, 0, 0, 0);
        send_tok(11, 1, 1, 0, 0);
        send_tok(15, 0, 0, 0, 0);
        check("t4_err", err, 1);
        wait_avail();
        read_row(6, row);
        check("t4_zz59_nat54", cf(row, 6), 2);
        release_bank();

        // Block 5: saturation with qt 255, run<15 size 0 ends the block
        send_tok(0, 11, 2047, 0, 2);
        send_tok(0, 11, 0, 0, 2);
        send_tok(0, 2, 0, 0, 2);
        send_tok(5, 0, 0, 0, 2);
        wait_avail();
        read_row(0, row);
        check("t5_sat_pos", cf(row, 0), 32767);
        check("t5_sat_neg", cf(row, 1), -32768);
        read_row(1, row);
        check("t5_neg_nosat", cf(row, 0), -765);
        release_bank();

        // Blocks A,B,C fill every bank; block D must stall
        send_tok(0, 2, 2, 0, 3);
        send_tok(0, 0, 0, 1, 3);
        send_tok(0, 2, 3, 0, 3);
        send_tok(0, 0, 0, 1, 3);
        send_tok(0, 3, 4, 0, 3);
        send_tok(0, 0, 0, 1, 3);
        for (int i = 0; i < 4; i++) tick();
        in_valid = 1'b1;
        in_run   = 4'd0;
        in_size  = 4'd1;
        in_amp   = 11'd1;
        in_eob   = 1'b0;
        in_tbl   = 2'd3;
        tick();
        check("t6_stall", in_ready, 0);
        wait_avail();
        read_row(0, row);
        check("t6_blk_a", cf(row, 0), 2);
        check("t6_still_stall", in_ready, 0);
        release_bank();
        check("t6_ready_after_done", in_ready, 1);
        tick();
        in_valid = 1'b0;
        wait_avail();
        read_row(0, row);
        check("t6_blk_b", cf(row, 0), 3);
        release_bank();
        send_tok(0, 0, 0, 1, 3);

        // Reset with two full banks and a block in progress
        send_tok(0, 1, 1, 0, 0);
        rst = 1'b1;
        tick();
        check("t7_rst_ready", in_ready, 0);
        rst = 1'b0;
        tick();
        check("t7_avail", rd_avail, 0);
        check("t7_err", err, 0);
        check("t7_data", rd_data, 0);
        check("t7_ready", in_ready, 1);
        send_tok(0, 1, 1, 0, 0);
        send_tok(0, 0, 0, 1, 0);
        wait_avail();
        read_row(0, row);
        check("t7_qt_kept", cf(row, 0), 2);
        check("t7_nat1", cf(row, 1), 0);
        read_row(6, row);
        check("t7_stale_cleared", cf(row, 6), 0);
        release_bank();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop if the stimulus ever stalls beyond its own bounds.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
